// File: rtl/bus_interface_if.sv
// Host bus and register-file signals of the Xosera host register port.
//   slave  : the bus_interface block (samples host bus, drives read data and
//            the register write port)
//   master : the host / register-file side (drives host bus and reg_data_i)
// Signals:
//   bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i[3:0], bus_data_i[7:0]
//   bus_data_o[7:0], bus_data_oe_o
//   reg_write_strobe_o, reg_num_o[3:0], reg_data_o[15:0], reg_data_i[15:0]
interface bus_interface_if;
  logic        bus_cs_n_i;
  logic        bus_rd_nwr_i;
  logic        bus_bytesel_i;
  logic [3:0]  bus_reg_num_i;
  logic [7:0]  bus_data_i;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic        reg_write_strobe_o;
  logic [3:0]  reg_num_o;
  logic [15:0] reg_data_o;
  logic [15:0] reg_data_i;

  modport slave (
    input  bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
    input  reg_data_i,
    output bus_data_o, bus_data_oe_o,
    output reg_write_strobe_o, reg_num_o, reg_data_o
  );

  modport master (
    output bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
    output reg_data_i,
    input  bus_data_o, bus_data_oe_o,
    input  reg_write_strobe_o, reg_num_o, reg_data_o
  );
endinterface

// File: rtl/bus_interface.sv
// Host-side register port for Xosera.
// Synchronizes the asynchronous host chip-select into the clk domain, performs
// exactly one access per CS assertion, pairs even/odd byte writes into a single
// 16-bit register write with a one-cycle strobe, and returns the selected byte
// of reg_data_i for host reads.
// Ports:
//   clk      : system clock
//   reset_i  : asynchronous active-high reset
//   bus      : bus_interface_if.slave (host bus + register write/read port)
// Parameters:
//   SYNC_STAGES : number of synchronizer flops on bus_cs_n_i (2..3)
module bus_interface #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_i,
  bus_interface_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_accept;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   w_cs_s;
  logic [7:0]             w_rd_byte;

  logic [7:0]             r_even_latch;
  logic [7:0]             r_bus_data;
  logic                   r_bus_data_oe;
  logic                   r_strobe;
  logic [3:0]             r_reg_num;
  logic [15:0]            r_reg_data;

  // CS synchronizer chain; resets to 0 (asserted) so the FSM must first see a
  // synchronized CS-high before it can accept an access.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_cs_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], bus.bus_cs_n_i};
    end
  end

  assign w_cs_s = r_cs_sync[SYNC_STAGES-1];

  // Byte of the register read data selected by the host byte select.
  always_comb begin
    w_rd_byte = 8'h00;
    if (bus.bus_bytesel_i) begin
      w_rd_byte = bus.reg_data_i[7:0];
    end else begin
      w_rd_byte = bus.reg_data_i[15:8];
    end
  end

  // FSM state register; reset into HOLD so a CS held low across reset release
  // performs no access.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; w_accept marks the single cycle an access happens.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_cs_s) begin
          w_accept     = 1'b1;
          w_state_next = ST_HOLD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (w_cs_s) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_HOLD;
        end
      end
      default: begin
        w_state_next = ST_HOLD;
      end
    endcase
  end

  // Access datapath: even-byte latch, paired register write, read data/OE.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_even_latch  <= 8'h00;
      r_bus_data    <= 8'h00;
      r_bus_data_oe <= 1'b0;
      r_strobe      <= 1'b0;
      r_reg_num     <= 4'h0;
      r_reg_data    <= 16'h0000;
    end else begin
      r_strobe <= 1'b0;
      if (w_accept) begin
        if (bus.bus_rd_nwr_i) begin
          r_bus_data_oe <= 1'b1;
          r_bus_data    <= w_rd_byte;
        end else if (bus.bus_bytesel_i) begin
          // Even latch is deliberately kept so repeated odd writes reuse it.
          r_reg_data <= {r_even_latch, bus.bus_data_i};
          r_reg_num  <= bus.bus_reg_num_i;
          r_strobe   <= 1'b1;
        end else begin
          r_even_latch <= bus.bus_data_i;
        end
      end else if (r_state == ST_HOLD) begin
        if (w_cs_s) begin
          r_bus_data_oe <= 1'b0;
        end else if (r_bus_data_oe) begin
          // Track reg_data_i updates for the whole duration of a read.
          r_bus_data <= w_rd_byte;
        end
      end
    end
  end

  assign bus.bus_data_o         = r_bus_data;
  assign bus.bus_data_oe_o      = r_bus_data_oe;
  assign bus.reg_write_strobe_o = r_strobe;
  assign bus.reg_num_o          = r_reg_num;
  assign bus.reg_data_o         = r_reg_data;

endmodule

// File: tb/tb_bus_interface.sv
// Self-checking bench for bus_interface: scoreboard of expected register
// writes checked on every strobe, plus per-scenario timing/data checks.
module tb_bus_interface;

  localparam int SYNC = 2;
  localparam int LOW  = SYNC + 3;
  localparam int HIGH = SYNC + 2;

  logic clk;
  logic reset_i;

  bus_interface_if bif ();

  bus_interface #(.SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  num;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_strobes = 0;
  logic prev_strobe = 1'b0;

  // Scoreboard monitor: every strobe must match the oldest expected write and
  // last exactly one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_i && bif.reg_write_strobe_o) begin
      n_strobes++;
      n_checks++;
      if (prev_strobe !== 1'b0) $display("FAIL strobe_width: strobe high on consecutive cycles");
      else n_pass++;
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_strobe: got num=%h data=%h, want no strobe",
                 bif.reg_num_o, bif.reg_data_o);
      end else begin
        e = sb_q.pop_front();
        if ({bif.reg_num_o, bif.reg_data_o} !== {e.num, e.data})
          $display("FAIL strobe_data: got num=%h data=%h, want num=%h data=%h",
                   bif.reg_num_o, bif.reg_data_o, e.num, e.data);
        else n_pass++;
      end
    end
    prev_strobe = bif.reg_write_strobe_o;
  end

  task automatic set_bus(input logic rd, input logic bsel, input logic [3:0] num,
                         input logic [7:0] data);
    bif.bus_rd_nwr_i  = rd;
    bif.bus_bytesel_i = bsel;
    bif.bus_reg_num_i = num;
    bif.bus_data_i    = data;
  endtask

  task automatic host_access(input logic rd, input logic bsel, input logic [3:0] num,
                             input logic [7:0] data, input int low_cycles);
    @(negedge clk);
    set_bus(rd, bsel, num, data);
    bif.bus_cs_n_i = 1'b0;
    repeat (low_cycles) @(negedge clk);
    bif.bus_cs_n_i = 1'b1;
    repeat (HIGH) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    repeat (HIGH) @(negedge clk);
  endtask

  task automatic test_reset();
    bif.bus_cs_n_i = 1'b1;
    set_bus(1'b0, 1'b0, 4'h0, 8'h00);
    bif.reg_data_i = 16'h0000;
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bif.reg_write_strobe_o !== 1'b0) $display("FAIL reset_strobe: got %b want 0", bif.reg_write_strobe_o); else n_pass++;
    n_checks++; if (bif.reg_num_o !== 4'h0) $display("FAIL reset_num: got %h want 0", bif.reg_num_o); else n_pass++;
    n_checks++; if (bif.reg_data_o !== 16'h0000) $display("FAIL reset_data: got %h want 0000", bif.reg_data_o); else n_pass++;
    n_checks++; if (bif.bus_data_o !== 8'h00) $display("FAIL reset_bus_data: got %h want 00", bif.bus_data_o); else n_pass++;
    n_checks++; if (bif.bus_data_oe_o !== 1'b0) $display("FAIL reset_oe: got %b want 0", bif.bus_data_oe_o); else n_pass++;
    reset_i = 1'b0;
    repeat (HIGH) @(negedge clk);
  endtask

  task automatic test_write_pair();
    int s0;
    s0 = n_strobes;
    host_access(1'b0, 1'b0, 4'h2, 8'h12, LOW);
    sb_q.push_back('{num: 4'h2, data: 16'h1234});
    @(negedge clk);
    set_bus(1'b0, 1'b1, 4'h2, 8'h34);
    bif.bus_cs_n_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bif.reg_write_strobe_o !== (i == 3))
        $display("FAIL strobe_latency: edge %0d got %b want %b", i, bif.reg_write_strobe_o, (i == 3));
      else n_pass++;
    end
    repeat (LOW - 4) @(negedge clk);
    bif.bus_cs_n_i = 1'b1;
    repeat (HIGH + 3) @(negedge clk);
    n_checks++; if (bif.reg_data_o !== 16'h1234) $display("FAIL pair_data_held: got %h want 1234", bif.reg_data_o); else n_pass++;
    n_checks++; if (bif.reg_num_o !== 4'h2) $display("FAIL pair_num_held: got %h want 2", bif.reg_num_o); else n_pass++;
    n_checks++; if (n_strobes - s0 !== 1) $display("FAIL pair_strobe_count: got %0d want 1", n_strobes - s0); else n_pass++;
  endtask

  task automatic test_odd_only();
    int s0;
    do_reset();
    s0 = n_strobes;
    sb_q.push_back('{num: 4'h1, data: 16'h0056});
    host_access(1'b0, 1'b1, 4'h1, 8'h56, LOW);
    sb_q.push_back('{num: 4'h7, data: 16'h0078});
    host_access(1'b0, 1'b1, 4'h7, 8'h78, LOW);
    n_checks++; if (n_strobes - s0 !== 2) $display("FAIL odd_strobe_count: got %0d want 2", n_strobes - s0); else n_pass++;
    n_checks++; if (bif.reg_data_o !== 16'h0078) $display("FAIL odd_data: got %h want 0078", bif.reg_data_o); else n_pass++;
  endtask

  task automatic test_read();
    int s0;
    host_access(1'b0, 1'b0, 4'h3, 8'h9A, LOW);
    s0 = n_strobes;
    bif.reg_data_i = 16'hBEEF;
    // even-byte read: OE timing on both edges of CS
    @(negedge clk);
    set_bus(1'b1, 1'b0, 4'h3, 8'h00);
    bif.bus_cs_n_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bif.bus_data_oe_o !== (i == 3))
        $display("FAIL oe_rise: edge %0d got %b want %b", i, bif.bus_data_oe_o, (i == 3));
      else n_pass++;
    end
    n_checks++; if (bif.bus_data_o !== 8'hBE) $display("FAIL read_even: got %h want BE", bif.bus_data_o); else n_pass++;
    repeat (2) @(negedge clk);
    bif.bus_cs_n_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bif.bus_data_oe_o !== (i < 3))
        $display("FAIL oe_fall: edge %0d got %b want %b", i, bif.bus_data_oe_o, (i < 3));
      else n_pass++;
    end
    repeat (HIGH) @(negedge clk);
    // odd-byte read with a reg_data_i update during the access
    set_bus(1'b1, 1'b1, 4'h3, 8'h00);
    bif.bus_cs_n_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bif.bus_data_o !== 8'hEF) $display("FAIL read_odd: got %h want EF", bif.bus_data_o); else n_pass++;
    bif.reg_data_i = 16'h1234;
    @(negedge clk);
    n_checks++; if (bif.bus_data_o !== 8'h34) $display("FAIL read_track: got %h want 34", bif.bus_data_o); else n_pass++;
    repeat (2) @(negedge clk);
    bif.bus_cs_n_i = 1'b1;
    repeat (HIGH) @(negedge clk);
    n_checks++; if (n_strobes - s0 !== 0) $display("FAIL read_no_strobe: got %0d want 0", n_strobes - s0); else n_pass++;
    // even latch must survive the reads
    sb_q.push_back('{num: 4'h4, data: 16'h9A01});
    host_access(1'b0, 1'b1, 4'h4, 8'h01, LOW);
    n_checks++; if (bif.reg_data_o !== 16'h9A01) $display("FAIL latch_after_read: got %h want 9A01", bif.reg_data_o); else n_pass++;
  endtask

  task automatic test_long_hold();
    int s0;
    s0 = n_strobes;
    sb_q.push_back('{num: 4'h5, data: 16'h9A77});
    host_access(1'b0, 1'b1, 4'h5, 8'h77, 40);
    n_checks++; if (n_strobes - s0 !== 1) $display("FAIL long_hold_count: got %0d want 1", n_strobes - s0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s0;
    bif.reg_data_i = 16'hBEEF;
    @(negedge clk);
    set_bus(1'b1, 1'b0, 4'h6, 8'h00);
    bif.bus_cs_n_i = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (bif.bus_data_oe_o !== 1'b1) $display("FAIL mid_oe_before: got %b want 1", bif.bus_data_oe_o); else n_pass++;
    #2;
    reset_i = 1'b1;
    set_bus(1'b0, 1'b1, 4'h6, 8'h42);
    #1;
    n_checks++; if (bif.bus_data_oe_o !== 1'b0) $display("FAIL mid_oe_async: got %b want 0", bif.bus_data_oe_o); else n_pass++;
    n_checks++; if (bif.bus_data_o !== 8'h00) $display("FAIL mid_data_async: got %h want 00", bif.bus_data_o); else n_pass++;
    @(negedge clk);
    reset_i = 1'b0;
    s0 = n_strobes;
    repeat (10) @(negedge clk);
    n_checks++; if (n_strobes - s0 !== 0) $display("FAIL cs_low_through_reset: got %0d strobes want 0", n_strobes - s0); else n_pass++;
    bif.bus_cs_n_i = 1'b1;
    repeat (HIGH) @(negedge clk);
    sb_q.push_back('{num: 4'h6, data: 16'h0042});
    bif.bus_cs_n_i = 1'b0;
    repeat (LOW) @(negedge clk);
    bif.bus_cs_n_i = 1'b1;
    repeat (HIGH) @(negedge clk);
    n_checks++; if (n_strobes - s0 !== 1) $display("FAIL access_after_reset: got %0d strobes want 1", n_strobes - s0); else n_pass++;
  endtask

  task automatic test_latch_reset();
    host_access(1'b0, 1'b0, 4'h0, 8'hAA, LOW);
    do_reset();
    sb_q.push_back('{num: 4'h8, data: 16'h0055});
    host_access(1'b0, 1'b1, 4'h8, 8'h55, LOW);
    n_checks++; if (bif.reg_data_o !== 16'h0055) $display("FAIL latch_reset: got %h want 0055", bif.reg_data_o); else n_pass++;
  endtask

  initial begin
    reset_i = 1'b1;
    test_reset();
    test_write_pair();
    test_odd_only();
    test_read();
    test_long_hold();
    test_reset_mid();
    test_latch_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_interface.md
# bus_interface

Host-side register port for Xosera. It synchronizes an asynchronous 8-bit host bus (chip-select, read/write, byte select, 4-bit register number) into the `clk` domain. It pairs even/odd byte writes into one 16-bit register write and issues a one-cycle write strobe toward the blitter register file. For host reads it returns the selected byte of the 16-bit register read data.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `bus_cs_n_i`. Legal values are 2–3.
- `clk`  in  1  system clock.
- `reset_i`  in  1  reset; one clock; reset is asynchronous and active-high.
- `bus_cs_n_i`  in  1  host chip-select, active low, asynchronous to `clk`.
- `bus_rd_nwr_i`  in  1  1 = host read, 0 = host write.
- `bus_bytesel_i`  in  1  0 = even (high) byte [15:8], 1 = odd (low) byte [7:0].
- `bus_reg_num_i`  in  4  register number.
- `bus_data_i`  in  8  host write data.
- `bus_data_o`  out  8  host read data.
- `bus_data_oe_o`  out  1  read-data output enable (pad tristate control).
- `reg_write_strobe_o`  out  1  one-cycle register write strobe.
- `reg_num_o`  out  4  register number; valid with the strobe, held afterwards.
- `reg_data_o`  out  16  register write word; valid with the strobe, held afterwards.
- `reg_data_i`  in  16  register read data from the blitter.

## Operation
- `bus_cs_n_i` passes through a `SYNC_STAGES` flop chain. The chain output is `cs_s`.
- All other bus inputs are sampled directly in the cycle of acceptance.
- Host obligation: `bus_rd_nwr_i`, `bus_bytesel_i`, `bus_reg_num_i` and `bus_data_i` are stable from CS assertion until CS deassertion. CS must stay low for at least `SYNC_STAGES+2` clocks and high for at least `SYNC_STAGES+1` clocks.
- FSM states: IDLE, HOLD.
  - IDLE, `cs_s`=1: remain in IDLE.
  - IDLE, `cs_s`=0: perform the access (below) and go to HOLD.
  - HOLD, `cs_s`=0: remain in HOLD; exactly one access is performed per CS assertion.
  - HOLD, `cs_s`=1: go to IDLE.
- Even-byte write (`rd_nwr`=0, `bytesel`=0): `even_latch <= bus_data_i`. No strobe is issued.
- Odd-byte write (`rd_nwr`=0, `bytesel`=1):
  - `reg_data_o <= {even_latch, bus_data_i}`.
  - `reg_num_o <= bus_reg_num_i`.
  - `reg_write_strobe_o <= 1` for exactly one cycle.
- Read (`rd_nwr`=1): `bus_data_oe_o <= 1`.
  - While in HOLD, `bus_data_o` is reloaded every cycle: `reg_data_i[15:8]` when `bytesel`=0, `reg_data_i[7:0]` when `bytesel`=1.
  - The output therefore tracks a `reg_data_i` update that occurs during the access.
  - `bus_data_oe_o` clears on the HOLD→IDLE transition.
- `even_latch` rules:
  - It is shared by all register numbers; `reg_num_o` comes from the odd access only.
  - It is not cleared by an odd write, so repeated odd writes reuse the last even byte.
  - Reads never modify it.
- Odd write with no prior even write since reset: the high byte is 0x00.

## Timing
- Reset values:
  - `reg_write_strobe_o`=0, `reg_num_o`=0, `reg_data_o`=0x0000.
  - `bus_data_o`=0x00, `bus_data_oe_o`=0, `even_latch`=0x00.
  - Synchronizer flops = 0 (asserted), FSM = HOLD.
  - Consequence: after reset the FSM must observe a synchronized CS-high before it accepts an access. A CS held low across reset release performs no access.
- Reset mid-access: all outputs return to their reset values immediately (asynchronous). A partially paired even byte is lost.
- Acceptance latency (`SYNC_STAGES`=2): let E0 be the first rising edge that samples `bus_cs_n_i` low.
  - `cs_s` is low after E1.
  - At E2 the FSM accepts the access.
  - `reg_write_strobe_o` / `bus_data_oe_o` are high from E2. The strobe falls at E3.
- Release latency: let Ek be the first edge sampling `bus_cs_n_i` high.
  - FSM returns to IDLE at Ek+2.
  - `bus_data_oe_o` is low after Ek+2.
- Read data: `bus_data_o` is valid from E2 and reflects `reg_data_i` with 1-cycle latency while in HOLD.
- Back-to-back accesses: the minimum period between consecutive strobes is `2*SYNC_STAGES+3` clocks when the host obeys the minimum low/high times.
- A CS pulse shorter than one clock may be missed entirely; that is a host obligation violation.

## Test plan
- Reset, then even write 0x12 and odd write 0x34 to reg 2 → one strobe, `reg_num_o`=2, `reg_data_o`=0x1234. The strobe is high exactly one cycle, 3 edges after CS falls.
- After reset, odd write 0x56 to reg 1 with no even write → `reg_data_o`=0x0056. Then odd write 0x78 to reg 7 → `reg_data_o`=0x0078 with the high byte reused (0x00); second strobe has `reg_num_o`=7.
- `reg_data_i`=0xBEEF; read even byte then odd byte → `bus_data_o`=0xBE then 0xEF. OE rises at E2 and falls 2 edges after CS release. No strobe is issued and `even_latch` is unchanged.
- Hold CS low for 40 clocks on an odd write → exactly one strobe. Change `reg_data_i` mid-read → `bus_data_o` follows one cycle later.
- Assert `reset_i` during a read in HOLD → OE=0 and `bus_data_o`=0x00 immediately. With CS held low through reset release → no access until CS goes high and low again.
- Even write 0xAA, reset, odd write 0x55 → `reg_data_o`=0x0055, confirming the latch is cleared by reset.
